// File: rtl/touch_pkg.sv
// Shared types and FT6206 constants for the touch poller.
// Command encodings match the byte-level I2C controller interface.
package touch_pkg;

   typedef enum logic [2:0] {
      I2C_IDLE      = 3'd0,
      I2C_START     = 3'd1,
      I2C_STOP      = 3'd2,
      I2C_WRITE     = 3'd3,
      I2C_READ_ACK  = 3'd4,
      I2C_READ_NACK = 3'd5
   } i2c_cmd_t;

   typedef enum logic [3:0] {
      ST_INIT_START = 4'd0,
      ST_INIT_ADDR  = 4'd1,
      ST_INIT_REG   = 4'd2,
      ST_INIT_DATA  = 4'd3,
      ST_INIT_STOP  = 4'd4,
      ST_IDLE       = 4'd5,
      ST_START      = 4'd6,
      ST_ADDR_W     = 4'd7,
      ST_REG        = 4'd8,
      ST_RESTART    = 4'd9,
      ST_ADDR_R     = 4'd10,
      ST_READ       = 4'd11,
      ST_STOP       = 4'd12,
      ST_UPDATE     = 4'd13,
      ST_ERR_STOP   = 4'd14,
      ST_INIT_WAIT  = 4'd15
   } touch_state_t;

   localparam logic [7:0] FT_REG_TD_STATUS = 8'h02;
   localparam logic [7:0] FT_REG_THRESH    = 8'h80;
   localparam logic [2:0] LAST_READ_IDX    = 3'd4;

   // The READ state issues ACK reads until the final byte, which is NACKed.
   function automatic i2c_cmd_t state_cmd(input touch_state_t s, input logic last_byte);
      case (s)
         ST_INIT_START, ST_START, ST_RESTART:          state_cmd = I2C_START;
         ST_INIT_STOP, ST_STOP, ST_ERR_STOP:           state_cmd = I2C_STOP;
         ST_INIT_ADDR, ST_INIT_REG, ST_INIT_DATA,
         ST_ADDR_W, ST_REG, ST_ADDR_R:                 state_cmd = I2C_WRITE;
         ST_READ:  state_cmd = last_byte ? I2C_READ_NACK : I2C_READ_ACK;
         default:  state_cmd = I2C_IDLE;
      endcase
   endfunction

   function automatic logic state_is_cmd(input touch_state_t s);
      state_is_cmd = (state_cmd(s, 1'b0) != I2C_IDLE);
   endfunction

   function automatic logic [11:0] touch_coord(input logic [7:0] hi, input logic [7:0] lo);
      touch_coord = {hi[3:0], lo};
   endfunction

   // Counts above two are not valid FT6206 reports and read as no touch.
   function automatic logic [1:0] touch_count(input logic [7:0] status);
      touch_count = (status[3:0] <= 4'd2) ? status[1:0] : 2'd0;
   endfunction

endpackage

// File: rtl/poll_ticker.sv
// Free-running wrap counter: o_tick pulses for one cycle each time
// the count passes TICKS-1 back to zero.
module poll_ticker #(
   parameter int unsigned TICKS = 120_000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_tick
);
   localparam int unsigned CW = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

   logic [CW-1:0] r_cnt;
   logic          r_tick;

   // Count and registered wrap pulse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (r_cnt == LAST) begin
         r_cnt  <= '0;
         r_tick <= 1'b1;
      end else begin
         r_cnt  <= r_cnt + CW'(1);
         r_tick <= 1'b0;
      end
   end

   assign o_tick = r_tick;

endmodule

// File: rtl/touch_poller.sv
// FT6206 touch sequencer: programs the threshold, then polls status and first point.
// Optional build macro TOUCH_IRQ_EN lets the active-low touch interrupt start a poll early.
module touch_poller
   import touch_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 12_000_000,
   parameter int unsigned POLL_HZ   = 100,
   parameter logic [6:0]  I2C_ADDR  = 7'h38,
   parameter logic [7:0]  THRESHOLD = 8'd128
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   output i2c_cmd_t    cmd,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [7:0]  tx_data,
   input  logic        cmd_done,
   input  logic [7:0]  rx_data,
   input  logic        ack,
   input  logic        touch_irq_n,
   output logic        touch_valid,
   output logic        touch_pressed,
   output logic [1:0]  num_touches,
   output logic [11:0] touch_x,
   output logic [11:0] touch_y,
   output logic        busy,
   output logic        error
);
   localparam int unsigned POLL_TICKS = CLK_HZ / POLL_HZ;
   localparam logic [7:0]  ADDR_WR    = {I2C_ADDR, 1'b0};
   localparam logic [7:0]  ADDR_RD    = {I2C_ADDR, 1'b1};

   touch_state_t r_state, w_state_nxt;
   logic         r_wait, w_wait_nxt;
   logic [2:0]   r_byte_idx, w_byte_nxt;
   logic         r_init_fail, w_fail_nxt;
   logic         r_tick_pend;
   logic [39:0]  r_rx_shift;
   i2c_cmd_t     r_cmd;
   logic         r_cmd_valid;
   logic [7:0]   r_tx_data;
   logic         r_touch_valid, r_pressed, r_busy, r_error;
   logic [1:0]   r_num;
   logic [11:0]  r_x, r_y;
   logic         w_tick, w_tick_any, w_irq_req, w_consume, w_nack;
   logic         w_last_byte, w_is_write, w_in_init, w_update;

   function automatic logic [7:0] state_tx(input touch_state_t s);
      case (s)
         ST_INIT_ADDR, ST_ADDR_W: state_tx = ADDR_WR;
         ST_INIT_REG:             state_tx = FT_REG_THRESH;
         ST_INIT_DATA:            state_tx = THRESHOLD;
         ST_REG:                  state_tx = FT_REG_TD_STATUS;
         ST_ADDR_R:               state_tx = ADDR_RD;
         default:                 state_tx = 8'h00;
      endcase
   endfunction

   poll_ticker #(.TICKS(POLL_TICKS)) u_ticker (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .o_tick  (w_tick)
   );

`ifdef TOUCH_IRQ_EN
   logic [1:0] r_irq_sync;

   // Two-flop synchronizer for the asynchronous touch interrupt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_irq_sync <= 2'b11;
      end else begin
         r_irq_sync <= {r_irq_sync[0], touch_irq_n};
      end
   end

   assign w_irq_req = ~r_irq_sync[1];
`else
   logic w_unused_irq;
   assign w_unused_irq = touch_irq_n;
   assign w_irq_req    = 1'b0;
`endif

   assign w_tick_any  = w_tick | r_tick_pend;
   assign w_last_byte = (r_byte_idx == LAST_READ_IDX);
   assign w_is_write  = (state_cmd(r_state, w_last_byte) == I2C_WRITE);
   assign w_in_init   = r_state inside {ST_INIT_START, ST_INIT_ADDR, ST_INIT_REG,
                                        ST_INIT_DATA, ST_INIT_STOP};
   assign w_update    = (r_state == ST_STOP) && r_wait && cmd_done;

   // Next-state logic: each command state is an ISSUE phase then a WAIT phase.
   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait;
      w_byte_nxt  = r_byte_idx;
      w_fail_nxt  = r_init_fail;
      w_nack      = 1'b0;
      w_consume   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_consume = w_tick_any;
            if (ena && (w_tick_any || w_irq_req)) begin
               w_state_nxt = ST_START;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_INIT_WAIT: begin
            w_consume = w_tick_any;
            if (w_tick_any) begin
               w_state_nxt = ST_INIT_START;
               w_fail_nxt  = 1'b0;
            end else begin
               w_state_nxt = ST_INIT_WAIT;
            end
         end
         ST_UPDATE: w_state_nxt = ST_IDLE;
         default: begin
            if (!r_wait) begin
               w_wait_nxt = r_cmd_valid && cmd_ready;
            end else if (!cmd_done) begin
               w_wait_nxt = 1'b1;
            end else if (w_is_write && !ack) begin
               w_wait_nxt  = 1'b0;
               w_nack      = 1'b1;
               w_fail_nxt  = w_in_init;
               w_state_nxt = ST_ERR_STOP;
            end else begin
               w_wait_nxt = 1'b0;
               case (r_state)
                  ST_INIT_START: w_state_nxt = ST_INIT_ADDR;
                  ST_INIT_ADDR:  w_state_nxt = ST_INIT_REG;
                  ST_INIT_REG:   w_state_nxt = ST_INIT_DATA;
                  ST_INIT_DATA:  w_state_nxt = ST_INIT_STOP;
                  ST_INIT_STOP:  w_state_nxt = ST_IDLE;
                  ST_START:      w_state_nxt = ST_ADDR_W;
                  ST_ADDR_W:     w_state_nxt = ST_REG;
                  ST_REG:        w_state_nxt = ST_RESTART;
                  ST_RESTART:    w_state_nxt = ST_ADDR_R;
                  ST_ADDR_R: begin
                     w_state_nxt = ST_READ;
                     w_byte_nxt  = 3'd0;
                  end
                  ST_READ: begin
                     if (w_last_byte) begin
                        w_state_nxt = ST_STOP;
                     end else begin
                        w_state_nxt = ST_READ;
                        w_byte_nxt  = r_byte_idx + 3'd1;
                     end
                  end
                  ST_STOP:       w_state_nxt = ST_UPDATE;
                  ST_ERR_STOP:   w_state_nxt = r_init_fail ? ST_INIT_WAIT : ST_IDLE;
                  default:       w_state_nxt = ST_IDLE;
               endcase
            end
         end
      endcase
   end

   // State register; command outputs are registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_INIT_START;
         r_wait      <= 1'b0;
         r_byte_idx  <= 3'd0;
         r_init_fail <= 1'b0;
         r_tick_pend <= 1'b0;
         r_cmd       <= I2C_IDLE;
         r_cmd_valid <= 1'b0;
         r_tx_data   <= 8'h00;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_wait      <= w_wait_nxt;
         r_byte_idx  <= w_byte_nxt;
         r_init_fail <= w_fail_nxt;
         r_tick_pend <= w_consume ? 1'b0 : (r_tick_pend | w_tick);
         r_cmd_valid <= state_is_cmd(w_state_nxt) && !w_wait_nxt;
         r_cmd       <= w_wait_nxt ? I2C_IDLE
                                   : state_cmd(w_state_nxt, w_byte_nxt == LAST_READ_IDX);
         r_tx_data   <= w_wait_nxt ? 8'h00 : state_tx(w_state_nxt);
         r_busy      <= (w_state_nxt != ST_IDLE);
      end
   end

   // Read bytes shift in oldest-first: status, XH, XL, YH, YL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_shift <= 40'h0;
      end else if ((r_state == ST_READ) && r_wait && cmd_done) begin
         r_rx_shift <= {r_rx_shift[31:0], rx_data};
      end else begin
         r_rx_shift <= r_rx_shift;
      end
   end

   // Touch outputs land on the edge that enters UPDATE; NACK sets the sticky error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_touch_valid <= 1'b0;
         r_pressed     <= 1'b0;
         r_num         <= 2'd0;
         r_x           <= 12'd0;
         r_y           <= 12'd0;
         r_error       <= 1'b0;
      end else begin
         r_touch_valid <= w_update;
         if (w_update) begin
            r_num     <= touch_count(r_rx_shift[39:32]);
            r_pressed <= (touch_count(r_rx_shift[39:32]) != 2'd0);
            r_x       <= touch_coord(r_rx_shift[31:24], r_rx_shift[23:16]);
            r_y       <= touch_coord(r_rx_shift[15:8], r_rx_shift[7:0]);
            r_error   <= 1'b0;
         end else if (w_nack) begin
            r_error   <= 1'b1;
         end else begin
            r_error   <= r_error;
         end
      end
   end

   assign cmd           = r_cmd;
   assign cmd_valid     = r_cmd_valid;
   assign tx_data       = r_tx_data;
   assign touch_valid   = r_touch_valid;
   assign touch_pressed = r_pressed;
   assign num_touches   = r_num;
   assign touch_x       = r_x;
   assign touch_y       = r_y;
   assign busy          = r_busy;
   assign error         = r_error;

endmodule

// File: tb/tb_touch_poller.sv
// Bench for touch_poller: an I2C controller + FT6206 register model drives the DUT
// with random handshake latency; touch results are predicted from the model's registers.
module tb_touch_poller;
   import touch_pkg::*;

   localparam int unsigned CLK_HZ  = 20_000;
   localparam int unsigned POLL_HZ = 100;
   localparam int unsigned TICKS   = CLK_HZ / POLL_HZ;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b0;
   logic        cmd_ready = 1'b0;
   logic        cmd_done = 1'b0;
   logic        ack = 1'b0;
   logic        touch_irq_n = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   i2c_cmd_t    cmd;
   logic        cmd_valid;
   logic [7:0]  tx_data;
   logic        touch_valid, touch_pressed, busy, error;
   logic [1:0]  num_touches;
   logic [11:0] touch_x, touch_y;

   int n_cmp = 0;
   int n_mis = 0;

   logic [7:0]  mem [0:255];
   logic [10:0] log_q [$];
   logic [10:0] exp_q [$];
   bit          ctl_busy = 1'b0;
   int          ctl_cnt = 0;
   int          byte_pos = 0;
   bit          rd_mode = 1'b0;
   logic [7:0]  ptr = 8'h00;
   int          reads = 0;
   bit          nack_addr = 1'b0;
   logic        pend_ack = 1'b1;
   logic [7:0]  pend_rx = 8'h00;

   touch_poller #(.CLK_HZ(CLK_HZ), .POLL_HZ(POLL_HZ), .I2C_ADDR(7'h38), .THRESHOLD(8'd128)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .tx_data(tx_data),
      .cmd_done(cmd_done), .rx_data(rx_data), .ack(ack), .touch_irq_n(touch_irq_n),
      .touch_valid(touch_valid), .touch_pressed(touch_pressed), .num_touches(num_touches),
      .touch_x(touch_x), .touch_y(touch_y), .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   function automatic logic [10:0] ent(input i2c_cmd_t c, input logic [7:0] b);
      ent = {c, (c == I2C_WRITE) ? b : 8'h00};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_stream(input string tag);
      check_eq({tag, "_len"}, log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < log_q.size()) check_eq(tag, log_q[i], exp_q[i]);
      end
   endtask

   task automatic expect_init();
      exp_q.delete();
      exp_q.push_back(ent(I2C_START, 8'h00));
      exp_q.push_back(ent(I2C_WRITE, 8'h70));
      exp_q.push_back(ent(I2C_WRITE, 8'h80));
      exp_q.push_back(ent(I2C_WRITE, 8'd128));
      exp_q.push_back(ent(I2C_STOP, 8'h00));
   endtask

   task automatic expect_poll();
      exp_q.delete();
      exp_q.push_back(ent(I2C_START, 8'h00));
      exp_q.push_back(ent(I2C_WRITE, 8'h70));
      exp_q.push_back(ent(I2C_WRITE, 8'h02));
      exp_q.push_back(ent(I2C_START, 8'h00));
      exp_q.push_back(ent(I2C_WRITE, 8'h71));
      for (int i = 0; i < 4; i++) exp_q.push_back(ent(I2C_READ_ACK, 8'h00));
      exp_q.push_back(ent(I2C_READ_NACK, 8'h00));
      exp_q.push_back(ent(I2C_STOP, 8'h00));
   endtask

   // Controller + slave model: decides cmd_ready at each falling edge and answers later.
   initial begin
      forever begin
         @(negedge clk);
         cmd_done = 1'b0;
         if (!rst_n) begin
            cmd_ready = 1'b0;
            ctl_busy  = 1'b0;
            ctl_cnt   = 0;
            byte_pos  = 0;
            reads     = 0;
         end else if (ctl_busy) begin
            cmd_ready = 1'b0;
            ctl_cnt--;
            if (ctl_cnt == 0) begin
               cmd_done = 1'b1;
               ack      = pend_ack;
               rx_data  = pend_rx;
               ctl_busy = 1'b0;
            end
         end else begin
            cmd_ready = ($urandom_range(0, 3) != 0);
            if (cmd_ready && cmd_valid) begin
               log_q.push_back(ent(cmd, tx_data));
               pend_ack = 1'b1;
               pend_rx  = 8'h00;
               case (cmd)
                  I2C_START: begin byte_pos = 0; reads = 0; end
                  I2C_WRITE: begin
                     if (byte_pos == 0) begin
                        rd_mode = tx_data[0];
                        if (tx_data[7:1] != 7'h38 || nack_addr) begin
                           pend_ack  = 1'b0;
                           nack_addr = 1'b0;
                        end
                     end else if (byte_pos == 1 && !rd_mode) begin
                        ptr = tx_data;
                     end else begin
                        mem[ptr] = tx_data;
                        ptr++;
                     end
                     byte_pos++;
                  end
                  I2C_READ_ACK, I2C_READ_NACK: begin
                     pend_rx = mem[ptr];
                     ptr++;
                     reads++;
                  end
                  default: ;
               endcase
               ctl_busy = 1'b1;
               ctl_cnt  = $urandom_range(1, 3);
            end
         end
      end
   end

   task automatic wait_busy_cycle(output bit ok);
      int n = 0;
      while (!busy && n < 4 * TICKS) begin @(posedge clk); #1; n++; end
      while (busy && n < 4 * TICKS) begin @(posedge clk); #1; n++; end
      ok = (n < 4 * TICKS);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_cmd_valid"}, cmd_valid, 1'b0);
      check_eq({tag, "_cmd"}, cmd, I2C_IDLE);
      check_eq({tag, "_tx_data"}, tx_data, 8'h00);
      check_eq({tag, "_touch_valid"}, touch_valid, 1'b0);
      check_eq({tag, "_pressed"}, touch_pressed, 1'b0);
      check_eq({tag, "_num"}, num_touches, 2'd0);
      check_eq({tag, "_x"}, touch_x, 12'd0);
      check_eq({tag, "_y"}, touch_y, 12'd0);
      check_eq({tag, "_busy"}, busy, 1'b0);
      check_eq({tag, "_error"}, error, 1'b0);
   endtask

   // Load the slave registers, await one poll and compare against the register contents.
   task automatic run_round(input logic [7:0] st, input logic [7:0] xh, input logic [7:0] xl,
                            input logic [7:0] yh, input logic [7:0] yl, input bit drop_ena);
      int n = 0;
      int exp_n;
      mem[2] = st; mem[3] = xh; mem[4] = xl; mem[5] = yh; mem[6] = yl;
      log_q.delete();
      if (drop_ena) begin
         while (!busy && n < 2 * TICKS) begin @(posedge clk); #1; n++; end
         repeat (3) @(posedge clk);
         #1 ena = 1'b0;
      end
      n = 0;
      while (!touch_valid && n < 2 * TICKS) begin @(posedge clk); #1; n++; end
      check_eq("touch_valid_seen", touch_valid, 1'b1);
      exp_n = (st[3:0] <= 4'd2) ? int'(st[3:0]) : 0;
      check_eq("touch_x", touch_x, {xh[3:0], xl});
      check_eq("touch_y", touch_y, {yh[3:0], yl});
      check_eq("num_touches", num_touches, exp_n);
      check_eq("touch_pressed", touch_pressed, exp_n != 0);
      check_eq("error_after_update", error, 1'b0);
      expect_poll();
      check_stream("poll_stream");
      @(posedge clk); #1;
      check_eq("touch_valid_pulse", touch_valid, 1'b0);
      check_eq("busy_idle", busy, 1'b0);
   endtask

   initial begin
      #400_000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "bench timed out");
   end

   initial begin
      bit ok;
      int n;
      logic [11:0] hold_x;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      ena = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;

      wait_busy_cycle(ok);
      check_eq("init_done", ok, 1'b1);
      expect_init();
      check_stream("init_stream");
      check_eq("init_error", error, 1'b0);
      check_eq("threshold_reg", mem[8'h80], 8'd128);

      run_round(8'h01, 8'h00, 8'd100, 8'h00, 8'd200, 1'b0);
      run_round(8'h0F, 8'h41, 8'h23, 8'h85, 8'h67, 1'b0);
      run_round(8'h02, 8'hFF, 8'hFF, 8'hF0, 8'h00, 1'b0);
      run_round(8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
      for (int r = 0; r < 6; r++) begin
         logic [7:0] st;
         st = 8'($urandom);
         if (r % 2 == 0) st[3:0] = 4'($urandom_range(0, 2));
         run_round(st, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      end

      // Address NACK: STOP only, sticky error, touch data untouched.
      hold_x = touch_x;
      nack_addr = 1'b1;
      log_q.delete();
      wait_busy_cycle(ok);
      check_eq("nack_done", ok, 1'b1);
      exp_q.delete();
      exp_q.push_back(ent(I2C_START, 8'h00));
      exp_q.push_back(ent(I2C_WRITE, 8'h70));
      exp_q.push_back(ent(I2C_STOP, 8'h00));
      check_stream("nack_stream");
      check_eq("nack_error", error, 1'b1);
      check_eq("nack_x_held", touch_x, hold_x);
      run_round(8'h01, 8'h07, 8'hAB, 8'h03, 8'hCD, 1'b0);

      // Reset during the third READ of a poll.
      mem[2] = 8'h01; mem[3] = 8'h02; mem[4] = 8'h22; mem[5] = 8'h01; mem[6] = 8'h33;
      n = 0;
      while (reads != 3 && n < 3 * TICKS) begin @(posedge clk); #1; n++; end
      check_eq("third_read_reached", reads, 3);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midread_reset");
      repeat (3) @(posedge clk);
      #1;
      log_q.delete();
      rst_n = 1'b1;
      wait_busy_cycle(ok);
      check_eq("reinit_done", ok, 1'b1);
      expect_init();
      check_stream("reinit_stream");

      // ena dropped mid-poll: transaction completes, then nothing starts.
      run_round(8'h01, 8'h03, 8'h10, 8'h02, 8'h20, 1'b1);
      log_q.delete();
      repeat (3 * TICKS) @(posedge clk);
      #1;
      check_eq("ena_off_no_cmds", log_q.size(), 0);
      check_eq("ena_off_busy", busy, 1'b0);
      ena = 1'b1;
      run_round(8'h02, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
